// File: rtl/burst_read_master_pkg.sv
// Shared types and constants for the burst read master.
package burst_read_master_pkg;

  // Controller states: waiting for a command, issuing reads, waiting for the stream to empty.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Output buffer depth; also the credit limit on words held in the buffer or in flight.
  localparam int FIFO_DEPTH = 3;

endpackage

// File: rtl/burst_read_master_if.sv
// Command, memory-port and output-stream signals of the burst read master.
interface burst_read_master_if #(
  parameter int addrW = 8,
  parameter int dataW = 16,
  parameter int lenW  = 8
);
  logic             cmdValid;
  logic             cmdReady;
  logic [addrW-1:0] cmdAddr;
  logic [lenW-1:0]  cmdLen;

  logic             memEn;
  logic             memWEn;
  logic [addrW-1:0] memAddr;
  logic [dataW-1:0] memDOut;

  logic             outValid;
  logic             outReady;
  logic [dataW-1:0] outData;
  logic             outLast;

  // Side that issues reads and produces the stream.
  modport master (
    input  cmdValid, cmdAddr, cmdLen, memDOut, outReady,
    output cmdReady, memEn, memWEn, memAddr, outValid, outData, outLast
  );

  // Environment side: command source, memory, stream sink.
  modport slave (
    output cmdValid, cmdAddr, cmdLen, memDOut, outReady,
    input  cmdReady, memEn, memWEn, memAddr, outValid, outData, outLast
  );
endinterface

// File: rtl/burst_read_master_rd_skid_fifo.sv
// Small synchronous FIFO holding returned read words until the stream sink takes them.
module rd_skid_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  pushData,
  input  logic          pop,
  output logic [W-1:0]  popData,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          full;
  logic          doPush;
  logic          doPop;

  // Flags and the head word; a push while full is only taken when the head leaves the same cycle.
  always_comb begin
    empty   = (count == CW'(0));
    full    = (count == CW'(DEPTH));
    doPop   = pop && !empty;
    doPush  = push && (!full || doPop);
    popData = store[rdPtr];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (doPush) begin
        store[wrPtr] <= pushData;
        wrPtr        <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
      end
      if (doPop) rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/burst_read_master.sv
// Burst read master: turns a (start address, length) command into sequential
// reads on a 1-cycle-latency memory port and streams the words out with a last marker.
//
// Handshakes: a transfer happens at a rising edge where valid and ready are both
// high. A source holds valid and its payload steady until that edge; ready may
// change freely. cmdReady is high only in IDLE (and never while rst is high);
// outValid/outData/outLast come from the FIFO head and do not change while
// outValid is high and outReady is low.
module burst_read_master
  import burst_read_master_pkg::*;
#(
  parameter int addrW = 8,
  parameter int dataW = 16,
  parameter int lenW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  burst_read_master_if.master bus,
  output logic                busy,
  output state_t              dbgState
);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int RW  = lenW + 1;
  localparam int CRW = CW + 1;

  state_t           state;
  state_t           stateNext;
  logic [addrW-1:0] addr;
  logic [RW-1:0]    remaining;
  logic             inflight;
  logic             inflightLast;
  logic             issue;
  logic             pop;
  logic             fifoEmpty;
  logic [CW-1:0]    fifoCount;
  logic [CRW-1:0]   credit;
  logic [dataW:0]   headWord;

  // Credit uses only registered counts so memEn never depends on outReady.
  assign credit = {1'b0, fifoCount} + {{CW{1'b0}}, inflight};

  // Next state and read issue.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmdValid) stateNext = RUN;
      end
      RUN: begin
        if (credit < CRW'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (remaining == RW'(1)) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the final word is leaving, so busy drops the next cycle.
        if (!inflight && (fifoCount == CW'(0) || (fifoCount == CW'(1) && pop)))
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Port outputs.
  always_comb begin
    bus.cmdReady = (state == IDLE) && !rst;
    busy         = (state != IDLE);
    dbgState     = state;
    bus.memEn    = issue;
    bus.memWEn   = 1'b0;
    bus.memAddr  = addr;
    bus.outValid = !fifoEmpty;
    bus.outData  = headWord[dataW-1:0];
    bus.outLast  = headWord[dataW];
    pop          = !fifoEmpty && bus.outReady;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Address/length counters and the one-deep record of the read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      remaining    <= '0;
      inflight     <= 1'b0;
      inflightLast <= 1'b0;
    end else begin
      inflight     <= issue;
      inflightLast <= issue && (remaining == RW'(1));
      if (state == IDLE && bus.cmdValid) begin
        addr      <= bus.cmdAddr;
        remaining <= {1'b0, bus.cmdLen} + RW'(1);
      end else if (issue) begin
        addr      <= addr + addrW'(1);
        remaining <= remaining - RW'(1);
      end
    end
  end

  // Returned words are captured only in the cycle their read is in flight.
  rd_skid_fifo #(
    .W     (dataW + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .pushData ({inflightLast, bus.memDOut}),
    .pop      (pop),
    .popData  (headWord),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );
endmodule

// File: tb/tb_burst_read_master.sv
// Self-checking bench for burst_read_master.
module tb_burst_read_master;
  import burst_read_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_read_master_if #(.addrW(8), .dataW(16), .lenW(8)) bus ();
  logic   busy;
  state_t dbgState;

  burst_read_master #(.addrW(8), .dataW(16), .lenW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .dbgState (dbgState)
  );

  // Memory: port A registered read for the DUT, port B modelled as direct preload writes.
  logic [15:0] mem [256];
  logic [15:0] memRd;
  always @(posedge clk) if (bus.memEn) memRd <= mem[bus.memAddr];
  assign bus.memDOut = memRd;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  logic [16:0] exp_q[$];
  logic [15:0] gotData[$];
  logic        gotLast[$];
  int          xferCyc[$];
  logic [7:0]  issueAddr[$];
  int          issueCyc[$];
  logic [15:0] heldData[$];
  bit          sawWEn;
  int          firstValid;
  bit          timedOut;

  // Reference model: a burst returns mem[(addr+i) mod 256] for i = 0..len, last on the final one.
  task automatic model_burst(input logic [7:0] a, input int len);
    for (int i = 0; i <= len; i++)
      exp_q.push_back({(i == len), mem[8'(int'(a) + i)]});
  endtask

  // ---------------- driver ----------------
  // mode 0: outReady always 1; 1: random; 2: low in cycles 3..8 after accept.
  task automatic run_burst(input logic [7:0] a, input logic [7:0] len, input int mode, input int abortAfter);
    int n;
    int cyc;
    bit done;
    gotData.delete(); gotLast.delete(); xferCyc.delete();
    issueAddr.delete(); issueCyc.delete(); heldData.delete();
    sawWEn = 0; firstValid = -1; timedOut = 0;
    n = 0;
    @(negedge clk);
    while (!bus.cmdReady && n < 200) begin @(negedge clk); n++; end
    bus.cmdValid = 1'b1; bus.cmdAddr = a; bus.cmdLen = len;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    cyc = 0; done = 0;
    while (!done && cyc < 2000) begin
      cyc++;
      case (mode)
        0:       bus.outReady = 1'b1;
        1:       bus.outReady = 1'($urandom_range(0, 1));
        default: bus.outReady = !(cyc >= 3 && cyc <= 8);
      endcase
      @(negedge clk);
      if (bus.memWEn) sawWEn = 1;
      if (bus.memEn) begin issueAddr.push_back(bus.memAddr); issueCyc.push_back(cyc); end
      if (bus.outValid && firstValid < 0) firstValid = cyc;
      if (bus.outValid && !bus.outReady) heldData.push_back(bus.outData);
      if (bus.outValid && bus.outReady) begin
        gotData.push_back(bus.outData); gotLast.push_back(bus.outLast); xferCyc.push_back(cyc);
        if (bus.outLast) done = 1;
        if (abortAfter > 0 && gotData.size() == abortAfter) done = 1;
      end
      @(posedge clk); #1;
    end
    timedOut = !done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; bus.cmdValid = 1'b0; bus.cmdAddr = '0; bus.cmdLen = '0; bus.outReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cmdReady !== 1'b0) $display("FAIL reset_cmdReady_in_rst got %b exp 0", bus.cmdReady); else passes++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmdReady !== 1'b1) $display("FAIL reset_cmdReady got %b exp 1", bus.cmdReady); else passes++;
    checks++; if (bus.memEn !== 1'b0) $display("FAIL reset_memEn got %b exp 0", bus.memEn); else passes++;
    checks++; if (bus.memWEn !== 1'b0) $display("FAIL reset_memWEn got %b exp 0", bus.memWEn); else passes++;
    checks++; if (bus.memAddr !== 8'h00) $display("FAIL reset_memAddr got %h exp 00", bus.memAddr); else passes++;
    checks++; if (bus.outValid !== 1'b0) $display("FAIL reset_outValid got %b exp 0", bus.outValid); else passes++;
    checks++; if (bus.outLast !== 1'b0) $display("FAIL reset_outLast got %b exp 0", bus.outLast); else passes++;
    checks++; if (bus.outData !== 16'h0000) $display("FAIL reset_outData got %h exp 0000", bus.outData); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
  endtask

  task automatic test_single;
    mem[8'h10] = 16'hBEEF;
    exp_q.delete(); model_burst(8'h10, 0);
    run_burst(8'h10, 8'd0, 0, 0);
    checks++; if (timedOut) $display("FAIL single_timeout got 1 exp 0"); else passes++;
    checks++; if (issueAddr.size() != 1) $display("FAIL single_issue_count got %0d exp 1", issueAddr.size()); else passes++;
    checks++; if (issueAddr.size() < 1 || issueAddr[0] !== 8'h10) $display("FAIL single_issue_addr got %h exp 10", (issueAddr.size() > 0) ? issueAddr[0] : 8'hxx); else passes++;
    checks++; if (firstValid != 3) $display("FAIL single_latency got %0d exp 3", firstValid); else passes++;
    checks++; if (gotData.size() != 1 || {gotLast[0], gotData[0]} !== exp_q[0]) $display("FAIL single_word got %0d words exp %h", gotData.size(), exp_q[0]); else passes++;
    checks++; if (sawWEn) $display("FAIL single_memWEn got 1 exp 0"); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy); else passes++;
    checks++; if (bus.cmdReady !== 1'b1) $display("FAIL single_cmdReady_after got %b exp 1", bus.cmdReady); else passes++;
  endtask

  task automatic test_burst;
    logic [16:0] e;
    exp_q.delete(); model_burst(8'h20, 3);
    run_burst(8'h20, 8'd3, 0, 0);
    checks++; if (gotData.size() != 4) $display("FAIL burst_count got %0d exp 4", gotData.size()); else passes++;
    for (int i = 0; i < gotData.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if ({gotLast[i], gotData[i]} !== e) $display("FAIL burst_word%0d got %h exp %h", i, {gotLast[i], gotData[i]}, e); else passes++;
    end
    checks++; if (xferCyc.size() != 4 || xferCyc[3] - xferCyc[0] != 3) $display("FAIL burst_no_bubbles got span %0d exp 3", (xferCyc.size() == 4) ? xferCyc[3] - xferCyc[0] : -1); else passes++;
  endtask

  task automatic test_backpressure;
    int early;
    logic [16:0] e;
    exp_q.delete(); model_burst(8'h20, 3);
    run_burst(8'h20, 8'd3, 2, 0);
    early = 0;
    foreach (issueCyc[i]) if (issueCyc[i] <= 8) early++;
    checks++; if (early != 3) $display("FAIL bp_issues_while_stalled got %0d exp 3", early); else passes++;
    checks++; if (heldData.size() != 6) $display("FAIL bp_held_cycles got %0d exp 6", heldData.size()); else passes++;
    foreach (heldData[i]) begin
      checks++; if (heldData[i] !== mem[8'h20]) $display("FAIL bp_held%0d got %h exp %h", i, heldData[i], mem[8'h20]); else passes++;
    end
    checks++; if (gotData.size() != 4) $display("FAIL bp_count got %0d exp 4", gotData.size()); else passes++;
    for (int i = 0; i < gotData.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if ({gotLast[i], gotData[i]} !== e) $display("FAIL bp_word%0d got %h exp %h", i, {gotLast[i], gotData[i]}, e); else passes++;
    end
  endtask

  task automatic test_wrap;
    logic [16:0] e;
    exp_q.delete(); model_burst(8'hFE, 3);
    run_burst(8'hFE, 8'd3, 0, 0);
    checks++; if (issueAddr.size() != 4) $display("FAIL wrap_issue_count got %0d exp 4", issueAddr.size()); else passes++;
    for (int i = 0; i < issueAddr.size(); i++) begin
      checks++; if (issueAddr[i] !== 8'(254 + i)) $display("FAIL wrap_addr%0d got %h exp %h", i, issueAddr[i], 8'(254 + i)); else passes++;
    end
    for (int i = 0; i < gotData.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if ({gotLast[i], gotData[i]} !== e) $display("FAIL wrap_word%0d got %h exp %h", i, {gotLast[i], gotData[i]}, e); else passes++;
    end
  endtask

  task automatic test_reset_mid;
    logic [16:0] e;
    run_burst(8'h30, 8'd7, 0, 2);
    checks++; if (gotData.size() != 2) $display("FAIL rstmid_words_before got %0d exp 2", gotData.size()); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.cmdReady !== 1'b0) $display("FAIL rstmid_cmdReady_in_rst got %b exp 0", bus.cmdReady); else passes++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.outValid !== 1'b0) $display("FAIL rstmid_outValid got %b exp 0", bus.outValid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else passes++;
    checks++; if (bus.cmdReady !== 1'b1) $display("FAIL rstmid_cmdReady got %b exp 1", bus.cmdReady); else passes++;
    exp_q.delete(); model_burst(8'h40, 0);
    run_burst(8'h40, 8'd0, 0, 0);
    checks++; if (gotData.size() != 1) $display("FAIL rstmid_new_count got %0d exp 1", gotData.size()); else passes++;
    e = exp_q.pop_front();
    checks++; if (gotData.size() < 1 || {gotLast[0], gotData[0]} !== e) $display("FAIL rstmid_new_word got %h exp %h", (gotData.size() > 0) ? {gotLast[0], gotData[0]} : 17'hx, e); else passes++;
  endtask

  task automatic test_back_to_back;
    int cyc, accepts, nLast, viol, n;
    int acceptCyc[2];
    int lastCyc[2];
    bit acc;
    logic [16:0] e;
    exp_q.delete(); model_burst(8'h50, 2); model_burst(8'h60, 1);
    gotData.delete(); gotLast.delete();
    acceptCyc = '{-1, -1}; lastCyc = '{-1, -1};
    n = 0;
    @(negedge clk);
    while (!bus.cmdReady && n < 200) begin @(negedge clk); n++; end
    bus.cmdValid = 1'b1; bus.cmdAddr = 8'h50; bus.cmdLen = 8'd2;
    bus.outReady = 1'($urandom_range(0, 1));
    cyc = 0; accepts = 0; nLast = 0; viol = 0;
    while (nLast < 2 && cyc < 500) begin
      cyc++;
      acc = bus.cmdValid && bus.cmdReady;
      if (accepts == 1 && nLast == 0 && bus.cmdReady) viol++;
      if (acc) begin acceptCyc[accepts] = cyc; accepts++; end
      if (bus.outValid && bus.outReady) begin
        gotData.push_back(bus.outData); gotLast.push_back(bus.outLast);
        if (bus.outLast) begin lastCyc[nLast] = cyc; nLast++; end
      end
      @(posedge clk); #1;
      if (acc && accepts == 1) begin bus.cmdAddr = 8'h60; bus.cmdLen = 8'd1; end
      if (acc && accepts == 2) bus.cmdValid = 1'b0;
      bus.outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.cmdValid = 1'b0;
    checks++; if (accepts != 2) $display("FAIL b2b_accepts got %0d exp 2", accepts); else passes++;
    checks++; if (viol != 0) $display("FAIL b2b_cmdReady_during_burst got %0d exp 0", viol); else passes++;
    checks++; if (acceptCyc[1] != lastCyc[0] + 1) $display("FAIL b2b_second_accept got %0d exp %0d", acceptCyc[1], lastCyc[0] + 1); else passes++;
    checks++; if (gotData.size() != 5) $display("FAIL b2b_count got %0d exp 5", gotData.size()); else passes++;
    for (int i = 0; i < gotData.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if ({gotLast[i], gotData[i]} !== e) $display("FAIL b2b_word%0d got %h exp %h", i, {gotLast[i], gotData[i]}, e); else passes++;
    end
  endtask

  task automatic test_random;
    logic [7:0] a;
    int len;
    logic [16:0] e;
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      a   = 8'($urandom_range(0, 255));
      len = (b == 6) ? 255 : int'($urandom_range(0, 20));
      exp_q.delete(); model_burst(a, len);
      run_burst(a, 8'(len), (b == 6) ? 0 : 1, 0);
      checks++; if (timedOut) $display("FAIL rand%0d_timeout got 1 exp 0", b); else passes++;
      checks++; if (gotData.size() != len + 1) $display("FAIL rand%0d_count got %0d exp %0d", b, gotData.size(), len + 1); else passes++;
      checks++; if (issueAddr.size() != len + 1) $display("FAIL rand%0d_issues got %0d exp %0d", b, issueAddr.size(), len + 1); else passes++;
      for (int i = 0; i < gotData.size() && exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        checks++; if ({gotLast[i], gotData[i]} !== e) $display("FAIL rand%0d_word%0d got %h exp %h", b, i, {gotLast[i], gotData[i]}, e); else passes++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/burst_read_master.md
Name: burst_read_master

Overview:
Read-side client for one port of the team's dual-port memory (addrW/dataW memory, 1-cycle registered read, output valid the cycle after the enable is sampled). It accepts a burst command (start address, length) and issues sequential reads on the memory port. It returns the words as a valid/ready stream with a last marker, absorbing downstream backpressure without losing data. It pairs with a writer on the opposite memory port to form a buffer/frame path.

Parameters:
addrW, 8, memory address width; addresses wrap modulo 2^addrW
dataW, 16, memory data width
lenW, 8, width of burst length field; burst size = cmdLen+1 words (1..2^lenW)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
cmdValid  input  1  burst command valid
cmdReady  output  1  command accepted when cmdValid&&cmdReady at clk edge
cmdAddr  input  addrW  start address
cmdLen  input  lenW  words minus one
memEn  output  1  drive to memory port enable
memWEn  output  1  drive to memory port write enable; constant 0
memAddr  output  addrW  read address to memory port
memDOut  input  dataW  memory read data (valid cycle after memEn sampled)
outValid  output  1  stream data valid
outReady  input  1  downstream ready; transfer on outValid&&outReady
outData  output  dataW  read word
outLast  output  1  high with final word of burst
busy  output  1  high from command accept until last word transferred

Behaviour:
- Reset (rst high at edge): state IDLE, FIFO emptied, inflight cleared; next cycle cmdReady=1, memEn=0, memWEn=0, memAddr=0, outValid=0, outLast=0, outData=0, busy=0. cmdReady is 0 during any cycle rst is high.
- FSM states IDLE, RUN, DRAIN.
- IDLE: cmdReady=1, busy=0. On accept: latch addr=cmdAddr, remaining=cmdLen+1 (lenW+1 bits, no overflow), go RUN.
- RUN: cmdReady=0, busy=1. memEn=1 when (fifoCount + inflight) < 3; memAddr=addr. Each issue: addr<=addr+1 (wraps 2^addrW-1 -> 0), remaining<=remaining-1, tag issued read last when remaining==1. On issue of last read go DRAIN.
- DRAIN: no issues; go IDLE when FIFO empty, inflight=0, and no push pending. busy drops in IDLE.
- inflight: register = memEn sampled last edge; that edge's memDOut (plus last tag) is pushed into the FIFO on the following edge.
- FIFO: 3 entries {data, last}, push and pop in the same cycle allowed; outValid = !empty; outData/outLast from head, held stable while outValid&&!outReady.
- memEn has no combinational path from outReady; the credit check uses registered counts only.
- Latency: command accepted at edge E0 -> memEn cycle 1 -> outValid first cycle 3. With outReady held high, one word per cycle, no bubbles.
- Backpressure: issue stalls once fifoCount+inflight reaches 3; no word is ever dropped or duplicated.
- Next command is accepted only in IDLE (earliest cycle after last word transferred); no overlap.
- rst mid-burst: abort immediately, discard FIFO and inflight data; the late memDOut is ignored.
- memDOut is sampled only when inflight=1.

Decomposition:
- Shared header: state encodings (IDLE/RUN/DRAIN), FIFO_DEPTH=3 localparam.
- One sub-module: rd_skid_fifo (depth 3, width dataW+1, sync reset, count output, simultaneous push/pop).
- Bench memory model: the team dual-port memory instantiated with port B as preloaded writer.

Test Plan:
- Mem[0x10]=0xBEEF; cmd addr=0x10 len=0, outReady=1 -> memEn one cycle addr 0x10; outValid cycle 3, outData=0xBEEF, outLast=1; busy low next cycle.
- Mem[i]=i*3; cmd addr=0x20 len=3, outReady=1 -> outData 0x60,0x63,0x66,0x69 on consecutive cycles, outLast only on 0x69.
- Same burst, outReady low for cycles 3-8 -> memEn stops after 3 issues; data held at 0x60 and stable; resumes in order, 4 words total.
- cmd addr=0xFE len=3 -> memAddr sequence 0xFE,0xFF,0x00,0x01; data matches memory.
- rst asserted one cycle mid-burst of len=7 after 2 words transferred -> next cycle outValid=0, busy=0, cmdReady=1; new cmd addr=0x40 len=0 returns Mem[0x40] only.
- Two commands back-to-back with cmdValid held -> second accepted only after first's outLast transfer; cmdReady=0 throughout first burst.
